// File: rtl/operand_loader.sv
// Operand loader: streams two 64-bit operands in bytewise, waits for an external adder,
// then streams the 64-bit sum out. Option: LOADER_PARITY_EN appends an XOR parity byte.
module operand_loader #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] sayi1,
    output logic [63:0] sayi2,
    input  logic [63:0] toplam,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam logic [2:0] LOAD_A  = 3'd0;
    localparam logic [2:0] LOAD_B  = 3'd1;
    localparam logic [2:0] SETTLE  = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] SEND    = 3'd4;

`ifdef LOADER_PARITY_EN
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [3:0] LAST_IDX = 4'd7;
`endif
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic [2:0]  state;
    logic [3:0]  byte_cnt;
    logic [3:0]  settle_cnt;
    logic [63:0] result;
    logic        in_fire;
    logic        out_fire;

    // in_ready is gated by rst directly so it is low for the whole reset pulse
    assign in_ready  = !rst && ((state == LOAD_A) || (state == LOAD_B));
    assign out_valid = (state == SEND);
    assign busy      = !((state == LOAD_A) && (byte_cnt == 4'd0));
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD_A;
            byte_cnt   <= 4'd0;
            settle_cnt <= 4'd0;
            sayi1      <= 64'd0;
            sayi2      <= 64'd0;
            result     <= 64'd0;
        end else begin
            case (state)
                LOAD_A: if (in_fire) begin
                    sayi1 <= {in_data, sayi1[63:8]};
                    if (byte_cnt == 4'd7) begin
                        byte_cnt <= 4'd0;
                        state    <= LOAD_B;
                    end else begin
                        byte_cnt <= byte_cnt + 4'd1;
                    end
                end
                LOAD_B: if (in_fire) begin
                    sayi2 <= {in_data, sayi2[63:8]};
                    if (byte_cnt == 4'd7) begin
                        byte_cnt   <= 4'd0;
                        settle_cnt <= 4'd0;
                        state      <= SETTLE;
                    end else begin
                        byte_cnt <= byte_cnt + 4'd1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) state <= CAPTURE;
                    else settle_cnt <= settle_cnt + 4'd1;
                end
                CAPTURE: begin
                    result   <= toplam;
                    byte_cnt <= 4'd0;
                    state    <= SEND;
                end
                SEND: if (out_fire) begin
                    byte_cnt <= (byte_cnt == LAST_IDX) ? 4'd0 : byte_cnt + 4'd1;
                    if (byte_cnt == LAST_IDX) state <= LOAD_A;
                end
                default: state <= LOAD_A;
            endcase
        end
    end

`ifdef LOADER_PARITY_EN
    logic [7:0] parity;
    always_comb begin
        parity = 8'd0;
        for (int i = 0; i < 8; i++) parity = parity ^ result[i*8 +: 8];
    end

    always_comb begin
        out_data = result[{byte_cnt[2:0], 3'b000} +: 8];
        if (byte_cnt[3]) out_data = parity;
    end
`else
    always_comb begin
        out_data = result[{byte_cnt[2:0], 3'b000} +: 8];
    end
`endif

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: a queue of expected result bytes built from the
// operands the bench drives, checked by one per-cycle compare process.
module tb_operand_loader;
    localparam int SETTLE = 3;

    logic        clk = 0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] sayi1, sayi2, toplam;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    operand_loader #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sayi1(sayi1), .sayi2(sayi2), .toplam(toplam), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    // the external adder
    assign toplam = sayi1 + sayi2;

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_in_cyc = 0;
    bit lat_armed = 0;
    int sent_cnt = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // compare process
    bit         prev_hold = 0;
    bit         prev_ov = 0;
    logic [7:0] prev_data;
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_ov && lat_armed) begin
                check("latency", 64'(cyc - last_in_cyc), 64'(SETTLE + 1));
                lat_armed = 0;
            end
            if (prev_hold) begin
                check("hold_valid", {63'd0, out_valid}, 64'd1);
                check("hold_data", {56'd0, out_data}, {56'd0, prev_data});
            end
            if (out_valid) check("in_ready_in_send", {63'd0, in_ready}, 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
                else begin
                    check("out_byte", {56'd0, out_data}, {56'd0, exp_q.pop_front()});
                    sent_cnt++;
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_ov   = out_valid;
        end else begin
            prev_hold = 0;
            prev_ov   = 0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        last_in_cyc = cyc;
        in_valid = 0;
    endtask

    task automatic load_word(input logic [63:0] w);
        for (int i = 0; i < 8; i++) send_byte(w[i*8 +: 8]);
    endtask

    task automatic push_exp(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] s;
        logic [7:0]  p;
        s = a + b;
        p = 8'd0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(s[i*8 +: 8]);
            p = p ^ s[i*8 +: 8];
        end
`ifdef LOADER_PARITY_EN
        exp_q.push_back(p);
`endif
        sent_cnt  = 0;
        lat_armed = 1;
    endtask

    task automatic run_txn(input logic [63:0] a, input logic [63:0] b);
        load_word(a);
        load_word(b);
        push_exp(a, b);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(n < 300), 64'd1);
        @(negedge clk);
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("idle_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_data = 8'h00; out_ready = 1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {56'd0, out_data}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_sayi1", sayi1, 64'd0);
        check("rst_sayi2", sayi2, 64'd0);

        // 1 + 2, first byte taken on the first edge after reset release
        rst = 0; in_data = 8'h01; in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        check("first_edge_xfer", sayi1, 64'h0100_0000_0000_0000);
        for (int i = 1; i < 8; i++) send_byte(8'h00);
        load_word(64'd2);
        push_exp(64'd1, 64'd2);
        check("model_first_byte", {56'd0, exp_q[0]}, 64'h03);
        check("sayi1_loaded", sayi1, 64'd1);
        check("sayi2_loaded", sayi2, 64'd2);
        @(negedge clk);
        check("settle_busy", {63'd0, busy}, 64'd1);
        drain();

        // wrap: no carry out of bit 63
        run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check("model_wrap_b0", {56'd0, exp_q[0]}, 64'h00);
        check("model_wrap_b7", {56'd0, exp_q[7]}, 64'h00);
        drain();

        // stall downstream on byte index 2
        run_txn(64'h1122_3344_5566_7788, 64'h0101_0101_0101_0101);
        begin
            int n = 0;
            while (sent_cnt < 2 && n < 100) begin
                @(posedge clk);
                n++;
            end
            check("stall_reach_timeout", 64'(n < 100), 64'd1);
        end
        #1 out_ready = 0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
        drain();

        // reset in the middle of sayi2
        load_word(64'hDEAD_BEEF_0000_1234);
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
        @(negedge clk);
        check("mid_busy", {63'd0, busy}, 64'd1);
        rst = 1;
        @(negedge clk);
        check("mid_rst_sayi1", sayi1, 64'd0);
        check("mid_rst_sayi2", sayi2, 64'd0);
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        rst = 0;
        run_txn(64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0001);
        drain();

        // in_valid flood while settling and sending
        out_ready = 0;
        run_txn(64'h0F0F_0F0F_0F0F_0F0F, 64'h1010_1010_1010_1010);
        repeat (SETTLE + 12) begin
            @(negedge clk);
            in_valid = 1;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 0;
        check("flood_sayi1", sayi1, 64'h0F0F_0F0F_0F0F_0F0F);
        check("flood_sayi2", sayi2, 64'h1010_1010_1010_1010);
        @(posedge clk);
        #1 out_ready = 1;
        drain();

        // parity vector: sum 0x0102030405060708
        run_txn(64'h0102_0304_0506_0700, 64'h0000_0000_0000_0008);
`ifdef LOADER_PARITY_EN
        check("model_parity", {56'd0, exp_q[8]}, 64'h08);
`else
        check("model_len", 64'(exp_q.size()), 64'd8);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: reached %0t without finishing", $time);
        $fatal(1);
    end
endmodule
